// File: rtl/btb_predictor_pkg.sv
// ============================================================================
// Module : btb_predictor_pkg
// Brief  : Shared widths, flush-code values and direction-counter encodings
//          for the IF-stage branch target buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package btb_predictor_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int FLUSH_CODE_SIZE = 3;

    // Flush codes produced by the ID-stage misprediction detector
    localparam int unsigned NICE_PRED = 0;
    localparam int unsigned JMP_FLUSH = 1;
    localparam int unsigned BR_FLUSH  = 2;
    localparam int unsigned NBR_FLUSH = 3;
    localparam int unsigned JR_FLUSH  = 4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

endpackage

`default_nettype wire

// File: rtl/btb_predictor_sat_counter2.sv
// ============================================================================
// Module : sat_counter2
// Brief  : Next-state function of a 2-bit saturating up/down counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter2
    import btb_predictor_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_up,
    output ctr_e o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_up) begin
            if (i_ctr != ST) begin
                o_ctr = ctr_e'(i_ctr + 2'd1);
            end
        end else begin
            if (i_ctr != SNT) begin
                o_ctr = ctr_e'(i_ctr - 2'd1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/btb_predictor.sv
// ============================================================================
// Module : btb_predictor
// Brief  : Direct-mapped BTB with 2-bit direction counters, combinational
//          next-PC lookup, ID-stage training and a saturating mispredict count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btb_predictor #(
    parameter int WORD_SIZE       = btb_predictor_pkg::WORD_SIZE,
    parameter int INDEX_BITS      = 4,
    parameter int FLUSH_CODE_SIZE = btb_predictor_pkg::FLUSH_CODE_SIZE
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WORD_SIZE-1:0]       pc_IF,
    output logic [WORD_SIZE-1:0]       pred_pc,
    output logic                       pred_hit,
    input  logic                       stall_ID,
    input  logic                       upd_valid,
    input  logic [WORD_SIZE-1:0]       upd_pc,
    input  logic                       upd_taken,
    input  logic [WORD_SIZE-1:0]       upd_target,
    input  logic [FLUSH_CODE_SIZE-1:0] flush_code,
    output logic [WORD_SIZE-1:0]       mispred_cnt
);

    import btb_predictor_pkg::*;

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;

    logic                 valid_q  [ENTRIES];
    logic                 valid_d  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [TAG_W-1:0]     tag_d    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [WORD_SIZE-1:0] target_d [ENTRIES];
    ctr_e                 ctr_q    [ENTRIES];
    ctr_e                 ctr_d    [ENTRIES];
    logic [WORD_SIZE-1:0] mispred_cnt_q;
    logic [WORD_SIZE-1:0] mispred_cnt_d;

    logic [INDEX_BITS-1:0] look_idx;
    logic [TAG_W-1:0]      look_tag;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_en;
    logic                  upd_hit;
    ctr_e                  upd_ctr_next;

    // Lookup reads only pre-edge contents; a same-cycle update is not bypassed
    always_comb begin
        look_idx = pc_IF[INDEX_BITS-1:0];
        look_tag = pc_IF[WORD_SIZE-1:INDEX_BITS];
        pred_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
        if (pred_hit && ctr_q[look_idx][1]) begin
            pred_pc = target_q[look_idx];
        end else begin
            pred_pc = pc_IF + WORD_SIZE'(1);
        end
    end

    always_comb begin
        upd_idx = upd_pc[INDEX_BITS-1:0];
        upd_tag = upd_pc[WORD_SIZE-1:INDEX_BITS];
        upd_en  = upd_valid && !stall_ID;
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    end

    sat_counter2 u_upd_ctr (
        .i_ctr (ctr_q[upd_idx]),
        .i_up  (upd_taken),
        .o_ctr (upd_ctr_next)
    );

    always_comb begin
        valid_d       = valid_q;
        tag_d         = tag_q;
        target_d      = target_q;
        ctr_d         = ctr_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = upd_ctr_next;
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                // Taken miss replaces whatever aliased entry lived at this index
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = WT;
            end
            if ((flush_code != FLUSH_CODE_SIZE'(NICE_PRED)) && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + WORD_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign mispred_cnt = mispred_cnt_q;

endmodule

`default_nettype wire

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- IF-stage next-PC predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Each cycle it takes the fetch PC and supplies the predicted next PC, which becomes the `pc` checked later by the ID-stage misprediction detector.
- It is trained from ID with the resolved outcome of each control instruction.
- It also keeps a saturating misprediction count driven by the detector's flush code.

Parameters:
- WORD_SIZE, 16, data/address width.
- INDEX_BITS, 4, BTB index width; 2**INDEX_BITS entries.
- FLUSH_CODE_SIZE, 3, flush code width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- pc_IF  input  WORD_SIZE  PC of the instruction being fetched.
- pred_pc  output  WORD_SIZE  predicted next fetch PC.
- pred_hit  output  1  lookup hit in a valid entry.
- stall_ID  input  1  ID frozen; blocks training.
- upd_valid  input  1  the ID instruction is a valid control instruction (branch, J-type, JPR/JRL).
- upd_pc  input  WORD_SIZE  PC of the ID instruction.
- upd_taken  input  1  resolved direction (1 for all jumps).
- upd_target  input  WORD_SIZE  resolved target (branch/jump target or register value).
- flush_code  input  FLUSH_CODE_SIZE  detector output for the ID instruction.
- mispred_cnt  output  WORD_SIZE  saturating count of non-NICE_PRED flush codes.

Behaviour:
- Storage per entry:
  - valid (1 bit)
  - tag = PC[WORD_SIZE-1:INDEX_BITS]
  - target (WORD_SIZE)
  - ctr (2 bits: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T)
- Index is PC[INDEX_BITS-1:0].
- Reset (async, reset_n low):
  - all valid = 0, all ctr = 01, targets/tags = 0, mispred_cnt = 0.
  - Outputs are then pred_hit = 0 and pred_pc = pc_IF + 1.
- Lookup is combinational, zero latency:
  - pred_hit = valid[idx] && tag[idx] == pc_IF tag.
  - pred_pc = target[idx] when pred_hit && ctr[idx][1]; otherwise pc_IF + 1.
  - The +1 wraps modulo 2**WORD_SIZE (0xFFFF -> 0x0000).
- Training happens on the rising clk edge when upd_valid && !stall_ID. Let i = upd_pc index, hit_u = the entry is valid with a matching tag.
  - hit_u, taken: ctr = min(ctr+1, 11); target = upd_target.
  - hit_u, not taken: ctr = max(ctr-1, 00); target unchanged.
  - miss, taken: allocate/replace: valid = 1, tag = upd_pc tag, target = upd_target, ctr = 10.
  - miss, not taken: no write.
- mispred_cnt increments by 1 on the same qualifier (upd_valid && !stall_ID) when flush_code != 3'd0. It saturates at 16'hFFFF (no wrap).
- Simultaneous lookup and update to the same index in one cycle:
  - The lookup sees pre-edge contents; there is no write-to-read bypass.
  - The new contents are visible from the next cycle.
- Stall: when stall_ID is high, no state changes, even if upd_valid is high. This prevents duplicate training while ID is held.
- A reset assertion mid-operation clears state immediately, regardless of clk. Training resumes on the first qualified edge after deassertion.
- A single write port and a single read port; no multi-cycle operations.

Decomposition:
- Shared package/header holds:
  - WORD_SIZE and FLUSH_CODE_SIZE.
  - Flush code constants: NICE_PRED = 0, JMP_FLUSH = 1, BR_FLUSH = 2, NBR_FLUSH = 3, JR_FLUSH = 4.
  - Counter encodings: SNT = 00, WNT = 01, WT = 10, ST = 11.
- One natural sub-module: sat_counter2, the 2-bit saturating up/down next-state function, instantiated per update path.
- The BTB array and mispred_cnt stay in btb_predictor.

Test Plan:
1. Reset, then pc_IF = 16'h0010 -> pred_hit = 0, pred_pc = 16'h0011, mispred_cnt = 0. Also pc_IF = 16'hFFFF -> pred_pc = 16'h0000.
2. Taken update upd_pc = 16'h0023, upd_target = 16'h0040, flush_code = 2 -> next cycle pc_IF = 16'h0023 gives pred_hit = 1, pred_pc = 16'h0040, mispred_cnt = 1.
3. From case 2 (ctr = 10), two not-taken updates at 16'h0023 -> after the first pred_pc = 16'h0024 (ctr 01). After the second ctr = 00. Three taken updates then reach ctr = 11 and do not exceed it.
4. Alias: entry for 16'h0023 present; taken update at upd_pc = 16'h0133 (same index 3, different tag), target 16'h0200 -> pc_IF = 16'h0023 misses (pred_pc = 16'h0024); pc_IF = 16'h0133 predicts 16'h0200. A not-taken miss at 16'h0043 writes nothing.
5. stall_ID = 1 with upd_valid = 1 and flush_code = 1 for 3 cycles -> BTB and mispred_cnt unchanged. Same-cycle lookup and update of index 5 -> the lookup returns old contents.
6. Force mispred_cnt to 16'hFFFE, then three mispredicting updates -> it holds 16'hFFFF. Assert reset_n low between clock edges -> the count goes to 0 and all lookups miss at once.
